// File: rtl/pdes_dispatch_ctrl.sv
// PDES dispatch/AEG controller: holds the AEG file, launches up to NUM_ENG phold
// engines on caep00, then publishes the minimum GVT and summed statistics.
module pdes_dispatch_ctrl #(
    parameter int NUM_ENG   = 4,
    parameter int NUM_STATS = 6,
    parameter int STAT_W    = 64,
    parameter int GVT_W     = 16,
    parameter int NUM_AEG   = 16,
    parameter int AEG_IDX_W = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              disp_inst_vld,
    input  logic [4:0]                        disp_inst,
    input  logic [17:0]                       disp_aeg_idx,
    input  logic                              disp_aeg_rd,
    input  logic                              disp_aeg_wr,
    input  logic [63:0]                       disp_aeg_wr_data,
    output logic [17:0]                       disp_aeg_cnt,
    output logic [15:0]                       disp_exception,
    output logic                              disp_idle,
    output logic                              disp_stall,
    output logic                              disp_rtn_data_vld,
    output logic [63:0]                       disp_rtn_data,
    output logic [47:0]                       cfg_addr,
    output logic [GVT_W-1:0]                  cfg_sim_end,
    output logic [7:0]                        cfg_num_init,
    output logic [7:0]                        cfg_lp_mask,
    output logic [NUM_ENG-1:0]                eng_rst_n,
    input  logic [NUM_ENG-1:0]                eng_done,
    input  logic [NUM_ENG*GVT_W-1:0]          eng_gvt,
    input  logic [NUM_ENG*NUM_STATS*STAT_W-1:0] eng_stat
);

    localparam int MASK_IDX    = 4;
    localparam int TMO_IDX     = 5;
    localparam int GVT_IDX     = 8;
    localparam int STATUS_IDX  = 9;
    localparam int STAT_BASE   = 10;
    localparam int RO_LAST     = STAT_BASE + NUM_STATS - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               state;
    logic [63:0]          aeg [NUM_AEG];
    logic                 cmd_q;
    logic                 timed_out;
    logic                 to_en;
    logic [63:0]          to_cnt;
    logic [NUM_ENG-1:0]   eff_mask;

    logic                 caep;
    logic                 accept;
    logic                 idx_ok;
    logic                 idx_ro;
    logic                 wr_ok;
    logic [AEG_IDX_W-1:0] aidx;
    logic [NUM_ENG-1:0]   eng_mask;
    logic [NUM_ENG-1:0]   launch_mask;
    logic                 all_done;
    logic                 timeout_hit;
    logic [63:0]          status_word;
    logic [3:0]           exc_set;
    logic [GVT_W-1:0]     cap_gvt;
    logic [STAT_W-1:0]    cap_stat [NUM_STATS];

    assign caep        = disp_inst_vld && (disp_inst == 5'd0);
    assign accept      = caep && (state == S_IDLE) && !cmd_q;
    assign idx_ok      = disp_aeg_idx < 18'(NUM_AEG);
    assign idx_ro      = (disp_aeg_idx >= 18'(GVT_IDX)) && (disp_aeg_idx <= 18'(RO_LAST));
    assign wr_ok       = disp_aeg_wr && idx_ok && !idx_ro;
    assign aidx        = disp_aeg_idx[AEG_IDX_W-1:0];
    assign eng_mask    = aeg[MASK_IDX][NUM_ENG-1:0];
    assign launch_mask = (eng_mask == '0) ? NUM_ENG'(1) : eng_mask;
    assign all_done    = (eng_done & eff_mask) == eff_mask;
    assign timeout_hit = (state == S_RUN) && !all_done && to_en && (to_cnt == 64'd1);
    assign status_word = {59'b0, timed_out, 1'b0, state};

    assign disp_aeg_cnt = 18'(NUM_AEG);
    assign disp_idle    = (state == S_IDLE) && !cmd_q;
    assign disp_stall   = (state != S_IDLE) || caep || cmd_q;

    assign cfg_addr     = aeg[0][47:0];
    assign cfg_sim_end  = aeg[1][GVT_W-1:0];
    assign cfg_num_init = aeg[2][7:0];
    assign cfg_lp_mask  = aeg[3][7:0];

    always_comb begin
        exc_set    = '0;
        exc_set[0] = disp_inst_vld && (disp_inst != 5'd0);
        exc_set[1] = (disp_aeg_rd || disp_aeg_wr) && !idx_ok;
        exc_set[2] = disp_aeg_wr && idx_ok && idx_ro;
        exc_set[3] = timeout_hit;
    end

    // NOTE: combinational reductions use blocking '=' so each loop step sees the previous one.
    always_comb begin
        cap_gvt = '1;
        for (int e = 0; e < NUM_ENG; e++) begin
            if (eff_mask[e] && eng_done[e] && (eng_gvt[e*GVT_W +: GVT_W] < cap_gvt))
                cap_gvt = eng_gvt[e*GVT_W +: GVT_W];
        end
        for (int s = 0; s < NUM_STATS; s++) begin
            cap_stat[s] = '0;
            for (int e = 0; e < NUM_ENG; e++) begin
                if (eff_mask[e])
                    cap_stat[s] = cap_stat[s] + eng_stat[(e*NUM_STATS+s)*STAT_W +: STAT_W];
            end
        end
    end

    // AEG file and read return; capture results share this block so each AEG has one driver.
    // NOTE: the AEG array is reset because software may read any AEG straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_AEG; i++) aeg[i] <= '0;
            disp_rtn_data_vld <= 1'b0;
            disp_rtn_data     <= '0;
        end else begin
            disp_rtn_data_vld <= disp_aeg_rd;
            if (disp_aeg_rd) begin
                if (!idx_ok)
                    disp_rtn_data <= '0;
                else if (aidx == AEG_IDX_W'(STATUS_IDX))
                    disp_rtn_data <= status_word;
                else
                    disp_rtn_data <= aeg[aidx];
            end else begin
                disp_rtn_data <= '0;
            end

            if (wr_ok)
                aeg[aidx] <= disp_aeg_wr_data;

            if (state == S_CAPTURE) begin
                aeg[GVT_IDX] <= 64'(cap_gvt);
                for (int s = 0; s < NUM_STATS; s++)
                    aeg[STAT_BASE+s] <= 64'(cap_stat[s]);
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cmd_q          <= 1'b0;
            timed_out      <= 1'b0;
            to_en          <= 1'b0;
            to_cnt         <= '0;
            eff_mask       <= '0;
            eng_rst_n      <= '0;
            disp_exception <= '0;
        end else begin
            disp_exception <= (accept ? 16'd0 : disp_exception) | 16'(exc_set);
            if (accept)
                cmd_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cmd_q) begin
                        cmd_q     <= 1'b0;
                        eff_mask  <= launch_mask;
                        eng_rst_n <= launch_mask;
                        to_cnt    <= aeg[TMO_IDX];
                        to_en     <= aeg[TMO_IDX] != 64'd0;
                        timed_out <= 1'b0;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: state <= S_RUN;
                S_RUN: begin
                    to_cnt <= to_cnt - 64'd1;
                    if (all_done) begin
                        state <= S_CAPTURE;
                    end else if (timeout_hit) begin
                        timed_out <= 1'b1;
                        state     <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    eng_rst_n <= '0;
                    state     <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdes_dispatch_ctrl.sv
// Self-checking bench for pdes_dispatch_ctrl: directed and randomized runs checked
// against expectations computed from the AEG/engine rules with plain arithmetic.
module tb_pdes_dispatch_ctrl;

    localparam int NE = 4;
    localparam int NS = 6;
    localparam int SW = 64;
    localparam int GW = 16;
    localparam int NA = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                disp_inst_vld;
    logic [4:0]          disp_inst;
    logic [17:0]         disp_aeg_idx;
    logic                disp_aeg_rd;
    logic                disp_aeg_wr;
    logic [63:0]         disp_aeg_wr_data;
    logic [17:0]         disp_aeg_cnt;
    logic [15:0]         disp_exception;
    logic                disp_idle;
    logic                disp_stall;
    logic                disp_rtn_data_vld;
    logic [63:0]         disp_rtn_data;
    logic [47:0]         cfg_addr;
    logic [GW-1:0]       cfg_sim_end;
    logic [7:0]          cfg_num_init;
    logic [7:0]          cfg_lp_mask;
    logic [NE-1:0]       eng_rst_n;
    logic [NE-1:0]       eng_done;
    logic [NE*GW-1:0]    eng_gvt;
    logic [NE*NS*SW-1:0] eng_stat;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_aeg [8];
    logic [15:0] exc_m;
    logic [GW-1:0] gvt_v [NE];
    logic [SW-1:0] stat_v [NE][NS];
    logic [63:0] last_gvt;
    logic        last_to;

    pdes_dispatch_ctrl #(
        .NUM_ENG(NE), .NUM_STATS(NS), .STAT_W(SW), .GVT_W(GW), .NUM_AEG(NA), .AEG_IDX_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_inst_vld(disp_inst_vld), .disp_inst(disp_inst),
        .disp_aeg_idx(disp_aeg_idx), .disp_aeg_rd(disp_aeg_rd), .disp_aeg_wr(disp_aeg_wr),
        .disp_aeg_wr_data(disp_aeg_wr_data), .disp_aeg_cnt(disp_aeg_cnt),
        .disp_exception(disp_exception), .disp_idle(disp_idle), .disp_stall(disp_stall),
        .disp_rtn_data_vld(disp_rtn_data_vld), .disp_rtn_data(disp_rtn_data),
        .cfg_addr(cfg_addr), .cfg_sim_end(cfg_sim_end), .cfg_num_init(cfg_num_init),
        .cfg_lp_mask(cfg_lp_mask), .eng_rst_n(eng_rst_n), .eng_done(eng_done),
        .eng_gvt(eng_gvt), .eng_stat(eng_stat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic aeg_write(input int idx, input logic [63:0] data);
        disp_aeg_idx     = 18'(idx);
        disp_aeg_wr_data = data;
        disp_aeg_wr      = 1'b1;
        tick();
        disp_aeg_wr      = 1'b0;
        if (idx < 8) m_aeg[idx] = data;
        else if (idx >= NA) exc_m[1] = 1'b1;
        else if (idx <= 10 + NS - 1) exc_m[2] = 1'b1;
    endtask

    task automatic aeg_read(input int idx, input logic [63:0] exp, input string tag);
        disp_aeg_idx = 18'(idx);
        disp_aeg_rd  = 1'b1;
        tick();
        disp_aeg_rd  = 1'b0;
        if (idx >= NA) exc_m[1] = 1'b1;
        check({tag, "_vld"}, 64'(disp_rtn_data_vld), 64'(1));
        check({tag, "_data"}, disp_rtn_data, exp);
    endtask

    task automatic randomize_engines();
        for (int e = 0; e < NE; e++) begin
            gvt_v[e] = GW'($urandom);
            for (int s = 0; s < NS; s++) stat_v[e][s] = {$urandom, $urandom};
        end
    endtask

    task automatic apply_engines();
        for (int e = 0; e < NE; e++) begin
            eng_gvt[e*GW +: GW] = gvt_v[e];
            for (int s = 0; s < NS; s++) eng_stat[(e*NS+s)*SW +: SW] = stat_v[e][s];
        end
    endtask

    // One full run; a caep00 is also poked while busy and must be ignored.
    task automatic do_run(input logic [63:0] mask, input logic [63:0] tmo,
                          input logic [NE-1:0] done, input string tag);
        logic [NE-1:0] eff;
        logic [GW-1:0] g;
        logic [63:0]   sum;
        logic          exp_to;
        int            act;
        int            guard;
        aeg_write(4, mask);
        aeg_write(5, tmo);
        apply_engines();
        eff    = (mask[NE-1:0] == '0) ? NE'(1) : mask[NE-1:0];
        exp_to = (eff & done) != eff;
        disp_inst     = 5'd0;
        disp_inst_vld = 1'b1;
        tick();
        disp_inst_vld = 1'b0;
        exc_m = '0;
        check({tag, "_stall_idle"}, 64'({disp_stall, disp_idle}), 64'(2'b10));
        check({tag, "_rst_pre"}, 64'(eng_rst_n), 64'(0));
        tick();
        check({tag, "_launch"}, 64'(eng_rst_n), 64'(eff));
        eng_done      = done;
        disp_inst_vld = 1'b1;
        act   = 1;
        guard = 0;
        while (!disp_idle && guard < 5000) begin
            tick();
            disp_inst_vld = 1'b0;
            if (eng_rst_n != '0) act++;
            guard++;
        end
        check({tag, "_finished"}, 64'(disp_idle), 64'(1));
        if (exp_to) check({tag, "_run_len"}, 64'(act), tmo + 64'd2);
        eng_done = '0;
        g = '1;
        for (int e = 0; e < NE; e++)
            if (eff[e] && done[e] && gvt_v[e] < g) g = gvt_v[e];
        if (exp_to) exc_m[3] = 1'b1;
        last_gvt = 64'(g);
        last_to  = exp_to;
        check({tag, "_exc"}, 64'(disp_exception), 64'(exc_m));
        aeg_read(8, 64'(g), {tag, "_gvt"});
        aeg_read(9, 64'(exp_to) << 4, {tag, "_status"});
        for (int s = 0; s < NS; s++) begin
            sum = '0;
            for (int e = 0; e < NE; e++) if (eff[e]) sum = sum + stat_v[e][s];
            aeg_read(10 + s, sum, $sformatf("%s_stat%0d", tag, s));
        end
        repeat (3) tick();
        check({tag, "_quiet"}, 64'({eng_rst_n, disp_idle}), 64'(1));
    endtask

    initial begin
        logic [63:0]   v;
        logic [63:0]   mask;
        logic [63:0]   tmo;
        logic [NE-1:0] dn;
        logic [NE-1:0] eff;
        rst_n = 1'b0;
        disp_inst_vld = 1'b0; disp_inst = '0; disp_aeg_idx = '0;
        disp_aeg_rd = 1'b0; disp_aeg_wr = 1'b0; disp_aeg_wr_data = '0;
        eng_done = '0; eng_gvt = '0; eng_stat = '0;
        exc_m = '0; last_gvt = '0; last_to = 1'b0;
        for (int i = 0; i < 8; i++) m_aeg[i] = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_idle", 64'(disp_idle), 64'(1));
        check("rst_stall", 64'(disp_stall), 64'(0));
        check("rst_exc", 64'(disp_exception), 64'(0));
        check("rst_eng", 64'(eng_rst_n), 64'(0));
        check("rst_cnt", 64'(disp_aeg_cnt), 64'(NA));
        check("rst_vld", 64'(disp_rtn_data_vld), 64'(0));
        aeg_read(9, 64'(0), "rst_status");
        aeg_read(12, 64'(0), "rst_stat2");

        for (int i = 0; i < 4; i++) aeg_write(i, {$urandom, $urandom});
        check("cfg_addr", 64'(cfg_addr), 64'(m_aeg[0][47:0]));
        check("cfg_sim_end", 64'(cfg_sim_end), 64'(m_aeg[1][GW-1:0]));
        check("cfg_num_init", 64'(cfg_num_init), 64'(m_aeg[2][7:0]));
        check("cfg_lp_mask", 64'(cfg_lp_mask), 64'(m_aeg[3][7:0]));

        aeg_write(6, 64'h1111_2222_3333_4444);
        v = {$urandom, $urandom};
        disp_aeg_idx = 18'd6; disp_aeg_wr_data = v;
        disp_aeg_wr = 1'b1; disp_aeg_rd = 1'b1;
        tick();
        disp_aeg_wr = 1'b0; disp_aeg_rd = 1'b0;
        check("rw_same_old", disp_rtn_data, 64'h1111_2222_3333_4444);
        m_aeg[6] = v;
        aeg_read(6, v, "rw_same_new");
        aeg_write(7, 64'hDEAD_BEEF);
        aeg_read(7, 64'hDEAD_BEEF, "spare7");

        randomize_engines();
        gvt_v[0] = 16'd100; gvt_v[2] = 16'd80;
        stat_v[0][0] = 64'd3; stat_v[2][0] = 64'd4;
        do_run(64'h5, 64'd0, 4'b0101, "dir_mask5");

        randomize_engines();
        do_run(64'h0, 64'd0, 4'b1111, "dir_mask0");

        randomize_engines();
        do_run(64'h3, 64'd50, 4'b0001, "dir_timeout");

        randomize_engines();
        do_run(64'h6, 64'd7, 4'b1001, "dir_none_done");

        aeg_write(8, 64'd123);
        check("ro_exc", 64'(disp_exception), 64'(exc_m));
        aeg_read(8, last_gvt, "ro_unchanged");
        aeg_read(20, 64'(0), "bad_rd");
        check("bad_exc", 64'(disp_exception), 64'(exc_m));

        disp_inst = 5'd3; disp_inst_vld = 1'b1;
        tick();
        disp_inst_vld = 1'b0;
        exc_m[0] = 1'b1;
        check("unimpl_exc", 64'(disp_exception), 64'(exc_m));
        repeat (2) tick();
        check("unimpl_idle", 64'({eng_rst_n, disp_idle}), 64'(1));
        aeg_read(9, 64'(last_to) << 4, "unimpl_status");

        for (int r = 0; r < 8; r++) begin
            randomize_engines();
            mask = 64'($urandom_range(0, 15)) | ({32'($urandom), 32'd0} & 64'hFFFF_FFF0_0000_0000);
            dn   = NE'($urandom_range(0, 15));
            eff  = (mask[NE-1:0] == '0) ? NE'(1) : mask[NE-1:0];
            if ((eff & dn) != eff) tmo = 64'($urandom_range(2, 40));
            else tmo = ($urandom_range(0, 1) == 0) ? 64'd0 : 64'($urandom_range(20, 90));
            do_run(mask, tmo, dn, $sformatf("rnd%0d", r));
        end

        randomize_engines();
        aeg_write(4, 64'hF);
        aeg_write(5, 64'd1000);
        apply_engines();
        disp_inst = 5'd0; disp_inst_vld = 1'b1;
        tick();
        disp_inst_vld = 1'b0;
        repeat (4) tick();
        check("abort_running", 64'(eng_rst_n), 64'hF);
        #2 rst_n = 1'b0;
        #1;
        check("abort_eng", 64'(eng_rst_n), 64'(0));
        check("abort_idle", 64'(disp_idle), 64'(1));
        check("abort_exc", 64'(disp_exception), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        aeg_read(0, 64'(0), "abort_aeg0");
        aeg_read(4, 64'(0), "abort_aeg4");
        aeg_read(5, 64'(0), "abort_aeg5");
        aeg_read(8, 64'(0), "abort_gvt");
        check("abort_cfg", 64'(cfg_addr), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
